noc_input_buffer: RTL
=====================

# noc_input_buffer

Per-direction input port buffer of the NoC router. It accepts 16-bit flits from the neighbouring router's link (or the local core) with a valid/ready handshake and stores them in a FIFO. It presents the head-of-line flit to the crossbar switch and the routing processor, and holds a crossbar path for the whole packet from head to tail. One instance exists per direction (N, S, W, E, L). Its data output drives the matching `*_cs_i` crossbar input.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries. Power of two, ≥2.
- `DATA_WIDTH`, default 16: flit width. Fixed at 16 by the flit format.

Ports:
- `clk_i`  input  1  clock; all state on the rising edge.
- `rst_n_i`  input  1  asynchronous active-low reset.
- `data_i`  input  16  flit from link.
- `valid_i`  input  1  `data_i` valid.
- `ready_o`  output  1  buffer can accept; equals !full.
- `data_o`  output  16  head-of-line flit to the crossbar demux.
- `flit_valid_o`  output  1  `data_o` holds a flit that may be sent this cycle.
- `req_o`  output  1  routing/arbitration request; held for the whole packet.
- `dst_x_o`  output  3  head flit destination X (`data_o[13:11]`), valid while `req_o`.
- `dst_y_o`  output  3  head flit destination Y (`data_o[10:8]`), valid while `req_o`.
- `grant_i`  input  1  round-robin arbiter grant for this port's request.
- `out_ready_i`  input  1  selected output direction can take a flit.
- `count_o`  output  $clog2(DEPTH+1)  FIFO occupancy.
- `err_o`  output  1  one-cycle pulse when an input flit is dropped for a protocol violation.

## Operation
- **Flit type** is `[15:14]`: 10 = head, 00 = body, 01 = tail, 11 = single (head and tail in one flit).
- **Write side:**
  - A push occurs when `valid_i && ready_o`.
  - An input-side flag `in_pkt` tracks the incoming packet.
  - Head or single is legal only when `in_pkt = 0`. Body or tail is legal only when `in_pkt = 1`.
  - A legal flit is written. A head sets `in_pkt`, a tail clears it, a single leaves it at 0.
  - An illegal flit is consumed but not written. `err_o = 1` in the next cycle, and `in_pkt` is unchanged.
- **Read-side FSM** states are IDLE, REQ and FWD:
  - IDLE: when the FIFO is non-empty and the front flit is head or single, go to REQ. A non-head flit at the front is impossible because of the write check.
  - REQ:
    - `req_o = 1` and `flit_valid_o = 1`.
    - On `grant_i && out_ready_i`, the head is popped.
    - If the popped flit is a single, go to IDLE. Otherwise go to FWD.
    - With no grant, stay in REQ and pop nothing.
  - FWD:
    - `req_o = 1` so the arbiter keeps the path locked, and `flit_valid_o = !empty`.
    - A flit is popped when `!empty && out_ready_i`; `grant_i` is ignored.
    - Popping a tail goes to IDLE.
  - In IDLE, `req_o = 0` and `flit_valid_o = 0`.
- **Pop condition:** pop = `flit_valid_o && out_ready_i && (state == FWD || grant_i)`.
- **Occupancy:** pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. `count_o` changes by +1 on push only, −1 on pop only, and 0 on simultaneous push and pop.
- **Full/empty:** push and pop in the same cycle are allowed whenever the FIFO is non-empty and not full. When full, `ready_o = 0` even if a pop occurs that cycle; there is no pass-through. When empty, there is no pop, and `data_o` is don't-care but holds the last read-pointer entry.
- **Reset values:**
  - Pointers, `count_o`, `in_pkt` and `err_o` are 0.
  - The FSM is in IDLE, so `req_o = 0` and `flit_valid_o = 0`.
  - `ready_o = 1`.
  - Reset mid-packet discards all stored flits and the open packet immediately.

## Timing
- Write-to-read latency is 1 cycle. A flit pushed at edge N is visible on `data_o` after edge N. If the FIFO was empty and the flit is a head, `req_o` rises after edge N+1, following the IDLE→REQ transition. There is no combinational path from `data_i` to `data_o`.
- `req_o`, `flit_valid_o`, `dst_x_o` and `dst_y_o` are decoded from registered state plus FIFO contents, with no dependence on `grant_i` in the same cycle.
- `ready_o` depends only on `count_o`.
- Throughput is 1 flit per cycle sustained in FWD with `out_ready_i = 1`.

## Test plan
- **Single flit:** reset, then push `0xC9xx` (single, dst x=1, y=1). Require:
  - `req_o = 1` with `dst_x_o = 1`, `dst_y_o = 1` two cycles after the push.
  - With `grant_i = 1` and `out_ready_i = 1`, one pop, `count_o` goes 1→0, and `req_o` returns to 0 in the next cycle.
- **Packet lock:** push head, 2 bodies and a tail back-to-back while granting once. Require:
  - `req_o` stays high through the tail.
  - The four flits leave in order on consecutive cycles.
  - The FSM ends in IDLE.
- **Full:** DEPTH = 4, `out_ready_i = 0`, push 5 flits. Require `ready_o = 0` after the fourth, `count_o = 4`, and the fifth flit is held on the link rather than lost.
- **Protocol violation:** push a body with `in_pkt = 0`. Require an `err_o` one-cycle pulse, `count_o` unchanged, and a following head accepted normally.
- **Simultaneous push/pop:** with `count_o = 2` in FWD, push and pop together. Require `count_o` to stay at 2 and the pointers to wrap correctly past entry 3.
- **Mid-packet reset:** assert `rst_n_i` low for 1 cycle in FWD with 3 flits stored. Require:
  - All outputs take their reset values immediately.
  - Stale flits never appear on `data_o` afterwards.

Source files
------------

// File: rtl/noc_input_buffer.sv
// NoC router input port: flit FIFO with write-side packet framing check and a
// read-side FSM that requests a crossbar path on a head flit and holds it to the tail.
module noc_input_buffer #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic [DATA_WIDTH-1:0]        data_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    output logic [DATA_WIDTH-1:0]        data_o,
    output logic                         flit_valid_o,
    output logic                         req_o,
    output logic [2:0]                   dst_x_o,
    output logic [2:0]                   dst_y_o,
    input  logic                         grant_i,
    input  logic                         out_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         err_o,
    output logic [1:0]                   state_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    localparam logic [1:0] FT_BODY   = 2'b00;
    localparam logic [1:0] FT_TAIL   = 2'b01;
    localparam logic [1:0] FT_HEAD   = 2'b10;
    localparam logic [1:0] FT_SINGLE = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FWD  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]           count_q;
    logic                    in_pkt_q;
    logic                    err_q;

    logic                    push, wr, pop, empty, legal;
    logic [1:0]              in_type, head_type;

    // Handshake: a flit transfers on any edge where valid_i && ready_o; ready_o
    // is !full from registered occupancy, so a pop never frees space in the same cycle.
    assign ready_o  = (count_q != CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign push     = valid_i && ready_o;
    assign in_type  = data_i[DATA_WIDTH-1 -: 2];
    // Head/single (msb set) only outside a packet, body/tail only inside one.
    assign legal    = (data_i[DATA_WIDTH-1] != in_pkt_q);
    assign wr       = push && legal;

    assign data_o    = mem_q[rd_ptr_q];
    assign head_type = data_o[DATA_WIDTH-1 -: 2];
    assign dst_x_o   = data_o[13:11];
    assign dst_y_o   = data_o[10:8];
    assign count_o   = count_q;
    assign err_o     = err_q;
    assign state_o   = state_q;

    always_comb begin
        state_d      = state_q;
        req_o        = 1'b0;
        flit_valid_o = 1'b0;
        pop          = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty && data_o[DATA_WIDTH-1]) state_d = REQ;
            end
            REQ: begin
                req_o        = 1'b1;
                flit_valid_o = 1'b1;
                pop          = grant_i && out_ready_i;
                if (pop) state_d = (head_type == FT_SINGLE) ? IDLE : FWD;
            end
            FWD: begin
                req_o        = 1'b1;
                flit_valid_o = !empty;
                pop          = !empty && out_ready_i;
                if (pop && head_type == FT_TAIL) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Storage is cleared on reset so flits of an aborted packet can never resurface.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            in_pkt_q <= 1'b0;
            err_q    <= 1'b0;
            state_q  <= IDLE;
        end else begin
            state_q <= state_d;
            err_q   <= push && !legal;
            if (wr) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
                if (in_type == FT_HEAD) in_pkt_q <= 1'b1;
                else if (in_type == FT_TAIL) in_pkt_q <= 1'b0;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({wr, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
